// File: rtl/perif_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO, status/baud registers and a baud-divided shift FSM.
// Optional even-parity bit after data bit 7 is enabled by defining UART_PARITY_EN.
module perif_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RESET = 16'd15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  inout  wire  [63:0] data,
  input  logic        chip_select,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [1:0]  size,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

`ifdef UART_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          ovf_r;
  logic [15:0]   baud_div_r, cur_div_r, baud_cnt_r;
  state_t        state_r, state_nxt_s;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r, shift_nxt_s;
  logic          par_r;
  logic          tx_r, tx_nxt_s, irq_r, irq_nxt_s;

  logic [1:0]  reg_sel_s;
  logic        rd_s, status_rd_s, push_req_s, push_ok_s, pop_s, tick_s;
  logic        full_s, empty_s, busy_s, ovf_set_s;
  logic [7:0]  cnt_ext_s, status_s;
  logic [63:0] rdata_s;
  logic        unused_s;

  assign reg_sel_s   = address[4:3];
  assign rd_s        = chip_select & read_en & ~write_en;
  assign status_rd_s = rd_s & (reg_sel_s == 2'b01);
  assign push_req_s  = chip_select & write_en & (reg_sel_s == 2'b00);
  assign full_s      = (count_r == CW'(FIFO_DEPTH));
  assign empty_s     = (count_r == CW'(0));
  assign busy_s      = (state_r != S_IDLE);
  assign tick_s      = busy_s & (baud_cnt_r == cur_div_r);
  assign pop_s       = (state_nxt_s == S_START) & (state_r != S_START);
  assign push_ok_s   = push_req_s & (~full_s | pop_s);
  assign ovf_set_s   = push_req_s & full_s & ~pop_s;
  assign cnt_ext_s   = 8'(count_r);
  assign status_s    = {ovf_r, cnt_ext_s[3:0], busy_s, empty_s, full_s};
  assign unused_s    = ^{address[31:5], address[2:0], size, data[63:16]};

  assign data = rd_s ? rdata_s : {64{1'bz}};
  assign tx   = tx_r;
  assign irq  = irq_r;

  // Register read multiplexer.
  always_comb begin
    rdata_s = 64'd0;
    case (reg_sel_s)
      2'b01:   rdata_s = {56'd0, status_s};
      2'b10:   rdata_s = {48'd0, baud_div_r};
      default: rdata_s = 64'd0;
    endcase
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage, pointers, sticky overflow and baud divisor register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'd0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      ovf_r      <= 1'b0;
      baud_div_r <= BAUD_RESET;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= data[7:0];
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_nxt_s;
      // A new overflow in the same cycle as a STATUS read must survive the clear.
      if (ovf_set_s)        ovf_r <= 1'b1;
      else if (status_rd_s) ovf_r <= 1'b0;
      if (chip_select & write_en & (reg_sel_s == 2'b10)) baud_div_r <= data[15:0];
    end
  end

  // Frame sequencing: next state, next shift contents and next line level.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:  state_nxt_s = empty_s ? S_IDLE : S_START;
      S_START: state_nxt_s = tick_s ? S_DATA : S_START;
      S_DATA: begin
        if (tick_s && (bit_idx_r == 3'd7)) begin
`ifdef UART_PARITY_EN
          state_nxt_s = S_PARITY;
`else
          state_nxt_s = S_STOP;
`endif
        end else begin
          state_nxt_s = S_DATA;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: state_nxt_s = tick_s ? S_STOP : S_PARITY;
`endif
      S_STOP: begin
        if (tick_s) state_nxt_s = empty_s ? S_IDLE : S_START;
        else        state_nxt_s = S_STOP;
      end
      default: state_nxt_s = S_IDLE;
    endcase

    shift_nxt_s = shift_r;
    if (pop_s)                               shift_nxt_s = mem_r[rd_ptr_r];
    else if ((state_r == S_DATA) && tick_s)  shift_nxt_s = {1'b0, shift_r[7:1]};
    else                                     shift_nxt_s = shift_r;

    tx_nxt_s = 1'b1;
    case (state_nxt_s)
      S_START:  tx_nxt_s = 1'b0;
      S_DATA:   tx_nxt_s = shift_nxt_s[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx_nxt_s = par_r;
`endif
      default:  tx_nxt_s = 1'b1;
    endcase

    irq_nxt_s = (count_nxt_s == CW'(0)) && (state_nxt_s == S_IDLE);
  end

  // FSM, baud counter and registered line/interrupt outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      baud_cnt_r <= 16'd0;
      cur_div_r  <= BAUD_RESET;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      par_r      <= 1'b0;
      tx_r       <= 1'b1;
      irq_r      <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      shift_r <= shift_nxt_s;
      tx_r    <= tx_nxt_s;
      irq_r   <= irq_nxt_s;
      if (pop_s | tick_s | (state_r == S_IDLE)) baud_cnt_r <= 16'd0;
      else                                      baud_cnt_r <= baud_cnt_r + 16'd1;
      // Divisor is latched only at bit boundaries so the running bit keeps its length.
      if ((state_r == S_IDLE) | tick_s) cur_div_r <= baud_div_r;
      if (state_r == S_START)              bit_idx_r <= 3'd0;
      else if ((state_r == S_DATA) & tick_s) bit_idx_r <= bit_idx_r + 3'd1;
`ifdef UART_PARITY_EN
      if (pop_s) par_r <= even_parity(mem_r[rd_ptr_r]);
`endif
    end
  end

endmodule

// File: tb/tb_perif_uart_tx.sv
// Directed self-checking bench for perif_uart_tx (honours UART_PARITY_EN when defined).
module tb_perif_uart_tx;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        chip_select, write_en, read_en;
  logic [1:0]  size;
  logic        drv_en;
  logic [63:0] drv_val;
  wire  [63:0] data;
  logic        tx, irq;
  int          checks = 0;
  int          errors = 0;

  assign data = drv_en ? drv_val : {64{1'bz}};

  perif_uart_tx #(.FIFO_DEPTH(8), .BAUD_RESET(16'd15)) dut (
    .clock(clock), .reset(reset), .address(address), .data(data),
    .chip_select(chip_select), .write_en(write_en), .read_en(read_en),
    .size(size), .tx(tx), .irq(irq)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end just after a falling edge.
  task automatic wr(input logic [1:0] sel, input logic [63:0] v);
    address = {27'd0, sel, 3'd0}; drv_val = v; drv_en = 1'b1;
    chip_select = 1'b1; write_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chip_select = 1'b0; write_en = 1'b0; drv_en = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] sel, input logic [63:0] exp, input string tag);
    address = {27'd0, sel, 3'd0}; chip_select = 1'b1; read_en = 1'b1;
    #1 chk(tag, data, exp);
    @(posedge clock);
    @(negedge clock);
    chip_select = 1'b0; read_en = 1'b0;
  endtask

  task automatic bits(input logic exp, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      chk(tag, {63'd0, tx}, {63'd0, exp});
    end
  endtask

  task automatic frame_bits(input logic [7:0] b, input int len);
    for (int i = 0; i < 8; i++) bits(b[i], len, "data_bit");
`ifdef UART_PARITY_EN
    bits(^b, len, "parity_bit");
`endif
  endtask

  initial begin
    reset = 1'b1; address = 32'd0; chip_select = 1'b0; write_en = 1'b0;
    read_en = 1'b0; size = 2'b11; drv_en = 1'b0; drv_val = 64'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state
    chk("reset_tx", {63'd0, tx}, 64'd1);
    chk("reset_irq", {63'd0, irq}, 64'd1);
    rd_chk(2'b01, 64'h02, "reset_status");
    rd_chk(2'b10, 64'd15, "reset_baud");
    rd_chk(2'b11, 64'd0, "reserved_read");

    // Single frame 0xA5 at 16 clocks per bit
    wr(2'b00, 64'hA5);
    chk("tx_high_after_push", {63'd0, tx}, 64'd1);
    bits(1'b0, 16, "start_a5");
    chk("irq_busy", {63'd0, irq}, 64'd0);
    frame_bits(8'hA5, 16);
    bits(1'b1, 16, "stop_a5");
    @(negedge clock);
    chk("irq_after_frame", {63'd0, irq}, 64'd1);
    chk("tx_idle_after_frame", {63'd0, tx}, 64'd1);

    // Overflow: first byte popped, eight queued, tenth dropped
    wr(2'b10, 64'd1000);
    for (int i = 0; i < 10; i++) wr(2'b00, 64'h10 + 64'(i));
    rd_chk(2'b01, 64'hC5, "status_full_ovf");
    rd_chk(2'b01, 64'h45, "status_ovf_cleared");
    reset = 1'b1;
    #1 chk("reset_async_tx", {63'd0, tx}, 64'd1);
    @(negedge clock);
    reset = 1'b0;
    rd_chk(2'b01, 64'h02, "status_after_flush");

    // Back-to-back frames 0x01 then 0x02 at 4 clocks per bit
    wr(2'b10, 64'd3);
    wr(2'b00, 64'h01);
    wr(2'b00, 64'h02);
    chk("start1_first_cycle", {63'd0, tx}, 64'd0);
    bits(1'b0, 3, "start_01");
    frame_bits(8'h01, 4);
    bits(1'b1, 4, "stop_01");
    bits(1'b0, 4, "start_02_no_gap");
    frame_bits(8'h02, 4);
    bits(1'b1, 4, "stop_02");
    @(negedge clock);
    chk("irq_after_pair", {63'd0, irq}, 64'd1);

    // Divisor change mid-frame: start keeps 8 clocks, later bits 4
    wr(2'b10, 64'd7);
    wr(2'b00, 64'h55);
    wr(2'b10, 64'd3);
    chk("start55_first_cycle", {63'd0, tx}, 64'd0);
    bits(1'b0, 7, "start_old_div");
    frame_bits(8'h55, 4);
    bits(1'b1, 4, "stop_55");
    @(negedge clock);
    chk("irq_after_55", {63'd0, irq}, 64'd1);
    rd_chk(2'b10, 64'd3, "baud_readback");

    // Reset in the middle of DATA
    wr(2'b00, 64'h00);
    bits(1'b0, 4, "start_00");
    bits(1'b0, 6, "data_00");
    reset = 1'b1;
    #1 chk("reset_mid_data_tx", {63'd0, tx}, 64'd1);
    chk("reset_mid_data_irq", {63'd0, irq}, 64'd1);
    @(negedge clock);
    reset = 1'b0;
    rd_chk(2'b01, 64'h02, "status_after_reset");
    bits(1'b1, 60, "no_frame_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
